// File: rtl/regfile_rdmux_pipe.sv
// Register file with one write port and NUM_RD independently enabled, registered read ports.
// Optional hardwired-zero entry 0 and same-cycle write-to-read forwarding.
module regfile_rdmux_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic              wr_fire;

  // Writes to entry 0 are dropped when it is hardwired to zero.
  assign wr_fire = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      data_d = mem_q[addr];
      if ((BYPASS != 0) && wr_fire && (wr_addr == addr)) begin
        data_d = wr_data;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data_d = '0;
      end
    end

    // Data holds its last value while the port is idle; only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[i];
        if (rd_en[i]) begin
          data_q <= data_d;
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_q;
    assign rd_valid[i]                 = valid_q;
  end

endmodule

// File: tb/tb_regfile_rdmux_pipe.sv
// Bench for regfile_rdmux_pipe: a default instance (zero reg + bypass) and a 16-bit, 3-port,
// 16-entry instance without zero reg or bypass, both checked against an array model.
module tb_regfile_rdmux_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_valid;

  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic [2:0]  b_rd_en;
  logic [11:0] b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_valid;

  regfile_rdmux_pipe #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  regfile_rdmux_pipe #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: register contents and the outputs expected after the latest edge.
  logic [31:0] ma [32];
  logic [15:0] mb [16];
  logic [31:0] ea_d [2];
  logic        ea_v [2];
  logic [15:0] eb_d [3];
  logic        eb_v [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] sel_a(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (a_wr_en && (a_wr_addr == a)) return a_wr_data;
    return ma[a];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 32; k++) ma[k] = '0;
    for (int k = 0; k < 16; k++) mb[k] = '0;
    for (int i = 0; i < 2; i++) begin ea_d[i] = '0; ea_v[i] = 1'b0; end
    for (int i = 0; i < 3; i++) begin eb_d[i] = '0; eb_v[i] = 1'b0; end
  endtask

  task automatic idle();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = '0; a_rd_addr = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0;
  endtask

  // Predict the next edge from the current inputs, advance the model, then cross the edge.
  task automatic tick();
    logic [31:0] pa_d [2];
    logic        pa_v [2];
    logic [15:0] pb_d [3];
    logic        pb_v [3];
    for (int i = 0; i < 2; i++) begin
      pa_v[i] = a_rd_en[i];
      pa_d[i] = a_rd_en[i] ? sel_a(a_rd_addr[i*5 +: 5]) : ea_d[i];
    end
    for (int i = 0; i < 3; i++) begin
      pb_v[i] = b_rd_en[i];
      pb_d[i] = b_rd_en[i] ? mb[b_rd_addr[i*4 +: 4]] : eb_d[i];
    end
    if (a_wr_en && (a_wr_addr != 5'd0)) ma[a_wr_addr] = a_wr_data;
    if (b_wr_en) mb[b_wr_addr] = b_wr_data;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin ea_d[i] = pa_d[i]; ea_v[i] = pa_v[i]; end
    for (int i = 0; i < 3; i++) begin eb_d[i] = pb_d[i]; eb_v[i] = pb_v[i]; end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    idle();
    clear_model();
    #1;
    chk("rst_async_a_valid", 64'(a_rd_valid), 64'h0);
    chk("rst_async_a_data", a_rd_data, 64'h0);
    chk("rst_async_b_valid", 64'(b_rd_valid), 64'h0);
    chk("rst_async_b_data", 64'(b_rd_data), 64'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("a_valid%0d", i), 64'(a_rd_valid[i]), 64'(ea_v[i]));
        chk($sformatf("a_data%0d", i), 64'(a_rd_data[i*32 +: 32]), 64'(ea_d[i]));
      end
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b_valid%0d", i), 64'(b_rd_valid[i]), 64'(eb_v[i]));
        chk($sformatf("b_data%0d", i), 64'(b_rd_data[i*16 +: 16]), 64'(eb_d[i]));
      end
    end
  end

  initial begin
    idle();
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_a", {a_rd_data[61:0], a_rd_valid}, 64'h0);
    chk("reset_b", 64'({b_rd_data, b_rd_valid}), 64'h0);

    // Load entries 1..31, read one back, then reset mid-cycle and read everything.
    for (int k = 1; k < 32; k++) begin
      a_wr_en = 1'b1; a_wr_addr = 5'(k); a_wr_data = $urandom | 32'h1;
      tick();
    end
    idle();
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd9};
    tick();
    chk("t1_pre_valid", 64'(a_rd_valid[0]), 64'h1);
    mid_reset();
    for (int k = 0; k < 32; k++) begin
      a_rd_en = 2'b11; a_rd_addr = {5'(31 - k), 5'(k)};
      tick();
    end
    chk("t1_post_data", a_rd_data, 64'h0);
    chk("t1_post_valid", 64'(a_rd_valid), 64'h3);

    // Basic write then read.
    idle();
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    tick();
    idle();
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd5};
    tick();
    chk("t2_data", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
    chk("t2_valid", 64'(a_rd_valid[0]), 64'h1);

    // Entry 0: hardwired zero on A, ordinary on B.
    idle();
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h12345678;
    b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 16'h5678;
    tick();
    idle();
    a_rd_en = 2'b11; b_rd_en = 3'b111;
    tick();
    chk("t3_zero_a", a_rd_data, 64'h0);
    chk("t3_zero_b", 64'(b_rd_data), 64'h5678_5678_5678);

    // Same-edge write and read of entry 7.
    idle();
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h1111_1111;
    b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 16'h1111;
    tick();
    a_wr_data = 32'h2222_2222; a_rd_en = 2'b10; a_rd_addr = {5'd7, 5'd0};
    b_wr_data = 16'h2222; b_rd_en = 3'b010; b_rd_addr = {4'd0, 4'd7, 4'd0};
    tick();
    chk("t4_bypass_a", 64'(a_rd_data[63:32]), 64'h2222_2222);
    chk("t4_nobypass_b", 64'(b_rd_data[31:16]), 64'h1111);
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    tick();
    chk("t4_next_b", 64'(b_rd_data[31:16]), 64'h2222);

    // Port 0 holds while idle; port 1 keeps reading.
    idle();
    for (int k = 3; k < 7; k++) begin
      a_wr_en = 1'b1; a_wr_addr = 5'(k);
      a_wr_data = (k == 3) ? 32'hA5A5A5A5 : 32'(k) * 32'h1111_1111;
      tick();
    end
    idle();
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd3};
    tick();
    for (int j = 0; j < 3; j++) begin
      a_rd_en = 2'b10; a_rd_addr = {5'(4 + j), 5'd3};
      tick();
      chk("t5_hold_data", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
      chk("t5_hold_valid", 64'(a_rd_valid[0]), 64'h0);
      chk("t5_port1", 64'(a_rd_data[63:32]), 64'(32'(4 + j) * 32'h1111_1111));
    end

    // Back-to-back writes to one address.
    idle();
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h1;
    tick();
    a_wr_data = 32'h2;
    tick();
    idle();
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd9};
    tick();
    chk("b2b_last_wins", 64'(a_rd_data[31:0]), 64'h2);

    // Sweep of the small instance with rotating port offsets.
    idle();
    for (int k = 0; k < 16; k++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(k); b_wr_data = 16'(k) * 16'h0101;
      tick();
    end
    idle();
    for (int r = 0; r < 16; r++) begin
      b_rd_en = 3'b111;
      b_rd_addr = {4'((r + 10) % 16), 4'((r + 5) % 16), 4'(r)};
      tick();
    end
    chk("t6_last", 64'(b_rd_data), 64'h0909_0404_0F0F);

    // Random traffic with frequent read/write address collisions.
    for (int c = 0; c < 600; c++) begin
      a_wr_en = 1'($urandom); a_wr_data = $urandom;
      a_wr_addr = ($urandom_range(0, 3) == 0) ? (($urandom & 1) != 0 ? 5'd31 : 5'd0)
                                              : 5'($urandom);
      a_rd_en = 2'($urandom);
      for (int i = 0; i < 2; i++)
        a_rd_addr[i*5 +: 5] = (($urandom & 1) != 0) ? a_wr_addr : 5'($urandom);
      b_wr_en = 1'($urandom); b_wr_data = 16'($urandom); b_wr_addr = 4'($urandom);
      b_rd_en = 3'($urandom);
      for (int i = 0; i < 3; i++)
        b_rd_addr[i*4 +: 4] = (($urandom & 1) != 0) ? b_wr_addr : 4'($urandom);
      tick();
      if (c == 300) mid_reset();
    end

    idle();
    tick();
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
